// File: rtl/mips32_pkg.sv
// Shared definitions for the pipe_mips32 front end: opcodes, instruction
// classes, default widths and the fetch-queue entry layout.
package mips32_pkg;

    localparam int MIPS_ADDR_W = 32;
    localparam int MIPS_DATA_W = 32;

    // Opcodes live in instruction bits [31:26].
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef enum logic [2:0] {
        RR_ALU = 3'd0,
        RM_ALU = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4,
        HALT   = 3'd5
    } instr_type_e;

    // One decoded-side queue entry: the instruction and its address + 1.
    typedef struct packed {
        logic [MIPS_DATA_W-1:0] ir;
        logic [MIPS_ADDR_W-1:0] npc;
    } fetch_entry_t;

    function automatic instr_type_e decode_type(input logic [5:0] op);
        instr_type_e t;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
            OP_LW:                                         t = LOAD;
            OP_SW:                                         t = STORE;
            OP_BNEQZ, OP_BEQZ:                             t = BRANCH;
            OP_HLT:                                        t = HALT;
            default:                                       t = RR_ALU;
        endcase
        return t;
    endfunction

    function automatic logic is_hlt(input logic [5:0] op);
        return op == OP_HLT;
    endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO with push/pop/flush, occupancy count and full/empty.
// DEPTH must be a power of two (pointers wrap naturally). A push while
// full is accepted only when a pop happens in the same cycle.
module mips32_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointers, count and storage; flush discards everything.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count gates what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && full && !pop));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(pop && !flush && empty));

endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch front end for pipe_mips32. Issues pipelined word
// requests from a PC, buffers returned words in a DEPTH-entry queue and
// presents {ir, npc} to decode over valid/ready.
//
// Handshakes: imem_req/imem_gnt transfer a request when both are high in
// the same cycle; ir_valid/ir_ready transfer the head entry when both are
// high; imem_rvalid has no back-pressure and responses return in order.
//
// Optional build macro FETCH_BYPASS_EN: with the queue empty, a kept
// response is presented on ir/npc in its arrival cycle and is only written
// to the queue if decode does not take it immediately.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = MIPS_ADDR_W,
    parameter int                DATA_W   = MIPS_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk1,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] npc,
    input  logic              ir_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_halted
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]  iq_count, inflight;
    logic              iq_full, iq_empty, af_full, af_empty;
    logic [ENT_W-1:0]  iq_rdata, iq_wdata;
    logic [ADDR_W-1:0] resp_addr, resp_npc;
    logic [CNT_W:0]    credit_used;
    logic              req_fire, resp_keep, bypass_hit;
    logic              iq_push, iq_pop, hlt_seen;
    logic [ENT_W-1:0]  head;
    logic              unused_flags;

    assign unused_flags = ^{iq_full, af_full, af_empty};

    // In-flight request addresses, in issue order. Never flushed: dropped
    // responses still retire their slot, so its count is every request
    // not yet answered, including those doomed by a redirect.
    mips32_sync_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_addr_fifo (
        .clk   (clk1),
        .rst   (rst),
        .push  (req_fire),
        .wdata (pc_q),
        .pop   (imem_rvalid),
        .flush (1'b0),
        .rdata (resp_addr),
        .count (inflight),
        .full  (af_full),
        .empty (af_empty)
    );

    // Instruction queue of {ir, npc}; a redirect discards its contents.
    mips32_sync_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_instr_fifo (
        .clk   (clk1),
        .rst   (rst),
        .push  (iq_push),
        .wdata (iq_wdata),
        .pop   (iq_pop),
        .flush (redirect_valid),
        .rdata (iq_rdata),
        .count (iq_count),
        .full  (iq_full),
        .empty (iq_empty)
    );

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = resp_keep && iq_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    // Issue credit, response keep/drop, queue control and decode outputs.
    always_comb begin
        // Queue entries plus unanswered requests never exceed DEPTH, which
        // is what keeps both FIFOs from overflowing.
        credit_used = {1'b0, iq_count} + {1'b0, inflight};
        imem_req    = !rst && !redirect_valid && !halted_q &&
                      (credit_used < (CNT_W + 1)'(DEPTH));
        imem_addr   = pc_q;
        req_fire    = imem_req && imem_gnt;

        resp_npc    = resp_addr + 1'b1;
        resp_keep   = imem_rvalid && !redirect_valid && (drop_cnt_q == '0);
        iq_wdata    = {imem_rdata, resp_npc};
        iq_push     = resp_keep && !(bypass_hit && ir_ready);
        iq_pop      = ir_ready && !iq_empty;
        hlt_seen    = resp_keep && is_hlt(imem_rdata[DATA_W-1 -: 6]);

        head = '0;
        if (!iq_empty) begin
            head = iq_rdata;
        end else if (bypass_hit) begin
            head = {imem_rdata, resp_npc};
        end
        ir_valid     = !iq_empty || bypass_hit;
        ir           = head[ENT_W-1 -: DATA_W];
        npc          = head[ADDR_W-1:0];
        fetch_halted = halted_q;
    end

    // Next PC, halt flag and count of responses still to be discarded.
    always_comb begin
        pc_d       = pc_q;
        halted_d   = halted_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
            // Every request still unanswered after this cycle belongs to
            // the old path; this already includes earlier pending drops,
            // so back-to-back redirects accumulate without double counting.
            drop_cnt_d = inflight - CNT_W'(imem_rvalid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 1'b1;
            end
            if (hlt_seen) begin
                halted_d = 1'b1;
            end
            if (imem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    // Fetch state registers with synchronous reset.
    always_ff @(posedge clk1) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            halted_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            halted_q   <= halted_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    a_drop_le_inflight : assert property (@(posedge clk1) disable iff (rst)
        drop_cnt_q <= inflight);

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_mips32_fetch_queue;
    import mips32_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] W_RESET_PC = 32'hFFFF_FFFE;

    // ---------------- clock / reset ----------------
    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic          rst, imem_req, imem_gnt, imem_rvalid, ir_valid, ir_ready;
    logic          redirect_valid, fetch_halted;
    logic [AW-1:0] imem_addr, npc, redirect_pc;
    logic [DW-1:0] imem_rdata, ir;

    logic          w_rst, w_req, w_valid, w_halted;
    logic [AW-1:0] w_addr, w_npc;
    logic [DW-1:0] w_ir;

    mips32_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
        .clk1(clk1), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir_valid(ir_valid), .ir(ir), .npc(npc), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_halted(fetch_halted)
    );

    // Second instance only to see a non-zero reset PC wrap past 2^32-1.
    mips32_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .RESET_PC(W_RESET_PC)) dut_wrap (
        .clk1(clk1), .rst(w_rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(1'b1), .imem_rvalid(1'b0), .imem_rdata('0),
        .ir_valid(w_valid), .ir(w_ir), .npc(w_npc), .ir_ready(1'b0),
        .redirect_valid(1'b0), .redirect_pc('0), .fetch_halted(w_halted)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    typedef struct { logic [AW-1:0] addr; bit doomed; } infl_t;
    typedef struct { int unsigned due; logic [AW-1:0] addr; } resp_t;

    fetch_entry_t exp_q[$];     // words decode should see, in order
    infl_t        m_infl[$];    // requests the model has issued, unanswered
    resp_t        mem_pend[$];  // memory responses scheduled
    logic [AW-1:0] m_pc;
    bit            m_halted;
    int unsigned   last_due;
    int unsigned   lat_min, lat_max;
    bit            hlt_en, hlt_rand;
    logic [AW-1:0] hlt_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Instruction memory contents: the word address itself (top opcode
    // bits cleared), except chosen HLT locations.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if ((hlt_en && a == hlt_addr) || (hlt_rand && a[3:0] == 4'hD))
            return {6'b111111, a[25:0]};
        return a & 32'h03FF_FFFF;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk1);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        ir_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        @(negedge clk1);
        check_eq("rst_imem_req", imem_req, 1'b0);
        check_eq("rst_ir_valid", ir_valid, 1'b0);
        check_eq("rst_fetch_halted", fetch_halted, 1'b0);
        check_eq("rst_ir", ir, '0);
        check_eq("rst_npc", npc, '0);
        rst = 1'b0;
        exp_q.delete(); m_infl.delete(); mem_pend.delete();
        m_pc = '0; m_halted = 1'b0; last_due = cyc;
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // schedule memory responses for actual grants, then advance the model.
    task automatic step(input bit redir, input logic [AW-1:0] rpc, input bit gnt, input bit ready);
        bit            rv, exp_req, accept, byp, exp_valid, consumed;
        logic [DW-1:0] rd;
        fetch_entry_t  exp_head;
        infl_t         h;
        int unsigned   due;
        @(negedge clk1);
        rv = (mem_pend.size() > 0) && (mem_pend[0].due == cyc);
        rd = rv ? mem_word(mem_pend[0].addr) : '0;
        if (rv) void'(mem_pend.pop_front());
        redirect_valid = redir; redirect_pc = rpc; imem_gnt = gnt; ir_ready = ready;
        imem_rvalid = rv; imem_rdata = rv ? rd : $urandom();
        #1;
        exp_req = !redir && !m_halted && (exp_q.size() + m_infl.size() < DEPTH);
        accept  = rv && !redir && (m_infl.size() > 0) && !m_infl[0].doomed;
        byp     = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp     = accept && (exp_q.size() == 0);
`endif
        exp_valid = (exp_q.size() > 0) || byp;
        check_eq("imem_req", imem_req, exp_req);
        if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
        check_eq("ir_valid", ir_valid, exp_valid);
        check_eq("fetch_halted", fetch_halted, m_halted);
        if (exp_valid) begin
            if (exp_q.size() > 0) begin
                exp_head = exp_q[0];
            end else begin
                exp_head.ir  = rd;
                exp_head.npc = m_infl[0].addr + 1'b1;
            end
            check_eq("ir", ir, exp_head.ir);
            check_eq("npc", npc, exp_head.npc);
        end
        if (imem_req && gnt) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_pend.push_back('{due: due, addr: imem_addr});
        end
        consumed = exp_valid && ready;
        if (consumed && exp_q.size() > 0) void'(exp_q.pop_front());
        if (rv && m_infl.size() > 0) begin
            h = m_infl.pop_front();
            if (accept) begin
                if (!(byp && ready)) begin
                    exp_head.ir  = rd;
                    exp_head.npc = h.addr + 1'b1;
                    exp_q.push_back(exp_head);
                end
                if (rd[31:26] == 6'b111111) m_halted = 1'b1;
            end
        end
        if (redir) begin
            exp_q.delete();
            foreach (m_infl[i]) m_infl[i].doomed = 1'b1;
            m_pc = rpc;
            m_halted = 1'b0;
        end else if (exp_req && gnt) begin
            m_infl.push_back('{addr: m_pc, doomed: 1'b0});
            m_pc = m_pc + 1'b1;
        end
        cyc++;
    endtask

    // ---------------- stimulus ----------------
    bit            r_redir;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] exp_a;

    initial begin
        rst = 1'b1; w_rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0; ir_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        hlt_en = 1'b0; hlt_rand = 1'b0; hlt_addr = '0;
        lat_min = 1; lat_max = 1;
        do_reset();

        // Streaming at L=1, then backpressure and release.
        repeat (25) step(1'b0, '0, 1'b1, 1'b1);
        repeat (10) step(1'b0, '0, 1'b1, 1'b0);
        repeat (12) step(1'b0, '0, 1'b1, 1'b1);

        // Redirect with requests in flight at L=3.
        do_reset(); lat_min = 3; lat_max = 3;
        repeat (6) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 32'h40, 1'b1, 1'b1);
        repeat (15) step(1'b0, '0, 1'b1, 1'b1);

        // Redirect landing on a response and a dequeue in steady state.
        do_reset(); lat_min = 2; lat_max = 2;
        repeat (8) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 32'h80, 1'b1, 1'b1);
        repeat (10) step(1'b0, '0, 1'b1, 1'b1);

        // Back-to-back redirects.
        lat_min = 3; lat_max = 3;
        step(1'b1, 32'h100, 1'b1, 1'b1);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        repeat (12) step(1'b0, '0, 1'b1, 1'b1);

        // HLT at address 5, drain, then redirect resumes fetch.
        do_reset(); lat_min = 1; lat_max = 1; hlt_en = 1'b1; hlt_addr = 32'd5;
        repeat (20) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 32'h10, 1'b1, 1'b1);
        repeat (15) step(1'b0, '0, 1'b1, 1'b1);
        hlt_en = 1'b0;

        // PC wrap through a redirect near the top of the address space.
        step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        repeat (12) step(1'b0, '0, 1'b1, 1'b1);

        // Random traffic: variable latency, gaps, stalls, redirects, halts.
        hlt_rand = 1'b1; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            r_redir = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 2))
                0:       r_pc = $urandom();
                1:       r_pc = AW'($urandom_range(0, 63));
                default: r_pc = 32'hFFFF_FFFE;
            endcase
            step(r_redir, r_pc, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end
        hlt_rand = 1'b0;

        // Non-zero RESET_PC: four grants wrap to 0 and 1, then credit stops.
        @(negedge clk1);
        check_eq("wrap_rst_req", w_req, 1'b0);
        check_eq("wrap_rst_ir", w_ir, '0);
        check_eq("wrap_rst_npc", w_npc, '0);
        w_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_a = W_RESET_PC + AW'(k);
            check_eq("wrap_req", w_req, (k < 4));
            if (k < 4) check_eq("wrap_addr", w_addr, exp_a);
            check_eq("wrap_valid", w_valid, 1'b0);
            check_eq("wrap_halted", w_halted, 1'b0);
            @(negedge clk1);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    // Time bound in case the stimulus ever stops advancing.
    initial begin
        #2_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
